m_data_mem_responder: RTL



---
 rtl/m_data_mem_responder.sv | 118 +++++++++++
 1 files changed

// File: rtl/m_data_mem_responder.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO window
// with a cycle counter, a console TX FIFO with valid/ready drain, and status.
module m_data_mem_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_WE,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data_to_mem,
  output logic [31:0] o_data_from_mem,
  output logic [31:0] o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_fault
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [31:0]   cycle_reg;
  logic          overflow_reg;
  logic          fault_reg;

  logic is_mmio, is_ram, is_cycle, is_tx, is_status;
  logic wr_en, tx_empty, tx_full, pop, push_req, push, push_drop;
  logic [31:0] count_ext;
  logic [2:0]  count_sat;
  logic        unused_addr_bits;

  // Byte offset bits are meaningless for word-only accesses.
  assign unused_addr_bits = ^i_address[1:0];

  assign is_mmio   = (i_address[31:16] == 16'hFFFF);
  assign is_ram    = !is_mmio && (i_address[31:2] < 30'(RAM_WORDS));
  assign is_cycle  = is_mmio && (i_address[15:2] == 14'd0);
  assign is_tx     = is_mmio && (i_address[15:2] == 14'd1);
  assign is_status = is_mmio && (i_address[15:2] == 14'd2);

  // Reset swallows any store issued in the same cycle.
  assign wr_en     = i_WE && !i_reset;
  assign tx_empty  = (count_reg == '0);
  assign tx_full   = (count_reg == CW'(FIFO_DEPTH));
  assign pop       = !tx_empty && i_tx_ready;
  assign push_req  = wr_en && is_tx;
  assign push      = push_req && (!tx_full || pop);
  assign push_drop = push_req && !push;

  always_ff @(posedge i_clk) begin
    if (wr_en && is_ram) begin
      mem[i_address[2 +: AW]] <= i_data_to_mem;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= i_data_to_mem;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cycle_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      fault_reg    <= 1'b0;
    end else begin
      cycle_reg <= (wr_en && is_cycle) ? i_data_to_mem : cycle_reg + 32'd1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // A dropped push outranks a same-cycle clear request.
      if (push_drop) begin
        overflow_reg <= 1'b1;
      end else if (wr_en && is_status && i_data_to_mem[2]) begin
        overflow_reg <= 1'b0;
      end
      if (wr_en && !is_ram && !is_mmio) begin
        fault_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    count_ext = 32'(count_reg);
    count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
  end

  always_comb begin
    o_data_from_mem = '0;
    if (is_ram) begin
      o_data_from_mem = mem[i_address[2 +: AW]];
    end else if (is_cycle) begin
      o_data_from_mem = cycle_reg;
    end else if (is_status) begin
      o_data_from_mem = {26'b0, count_sat, overflow_reg, tx_full, tx_empty};
    end
  end

  assign o_tx_valid = !tx_empty;
  assign o_tx_data  = tx_empty ? 32'd0 : fifo_mem[rd_ptr_reg];
  assign o_fault    = fault_reg;
endmodule
